decode_stage: RTL and testbench

Registered, parametrised RV32I/RV64I instruction decode stage with valid/ready handshake, 2-entry skid buffering, immediate generation and illegal-instruction detection. It sits between instruction fetch and the register-file/ALU stage. It produces the core's existing control-bundle encodings plus register indices, a sign-extended immediate and the forwarded PC. It fixes the I-type ALU_sel_2, AUIPC and unknown-opcode behaviour of the previous combinational decoder.

---
 rtl/decode_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: decodes on the input side into a control bundle, then holds it in a
// main register backed by one skid entry so in_ready can be a registered signal.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            we_regfile,
  output logic            we_datamem,
  output logic            re_datamem,
  output logic            we_pc,
  output logic            j_pc,
  output logic [2:0]      ALU_sel_1,
  output logic            ALU_sel_2,
  output logic            alu_m,
  output logic [1:0]      operand1_sel,
  output logic            operand2_sel,
  output logic [1:0]      rd_sel,
  output logic            illegal
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcFence  = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            we_regfile;
    logic            we_datamem;
    logic            re_datamem;
    logic            we_pc;
    logic            j_pc;
    logic [2:0]      alu_sel_1;
    logic            alu_sel_2;
    logic            alu_m;
    logic [1:0]      operand1_sel;
    logic            operand2_sel;
    logic [1:0]      rd_sel;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    in_ready_q, in_ready_d;

  bundle_t            dec;
  logic               legal;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;

  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    legal   = 1'b1;
    imm_sel = '0;
    dec.pc  = in_pc;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    // Matching on all seven opcode bits also rejects any instr[1:0] other than 2'b11.
    case (in_instr[6:0])
      OpcOp: begin
        dec.we_regfile = 1'b1;
        dec.alu_sel_1  = funct3;
        dec.alu_sel_2  = in_instr[30];
        if (ENABLE_M && funct7 == 7'b0000001) begin
          dec.alu_m     = 1'b1;
          dec.alu_sel_2 = 1'b0;
        end else if (funct7 == 7'b0000000) begin
          legal = 1'b1;
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OpcOpImm: begin
        dec.operand2_sel = 1'b1;
        dec.we_regfile   = 1'b1;
        dec.alu_sel_1    = funct3;
        dec.alu_sel_2    = (funct3 == 3'b101) ? in_instr[30] : 1'b0;
        imm_sel          = imm_i;
      end
      OpcLoad: begin
        dec.operand2_sel = 1'b1;
        dec.we_regfile   = 1'b1;
        dec.re_datamem   = 1'b1;
        dec.rd_sel       = 2'b01;
        imm_sel          = imm_i;
      end
      OpcStore: begin
        dec.operand2_sel = 1'b1;
        dec.we_datamem   = 1'b1;
        imm_sel          = imm_s;
      end
      OpcBranch: begin
        dec.operand1_sel = 2'b01;
        dec.operand2_sel = 1'b1;
        dec.we_pc        = 1'b1;
        imm_sel          = imm_b;
      end
      OpcJal: begin
        dec.operand1_sel = 2'b01;
        dec.operand2_sel = 1'b1;
        dec.we_regfile   = 1'b1;
        dec.j_pc         = 1'b1;
        dec.rd_sel       = 2'b10;
        imm_sel          = imm_j;
      end
      OpcJalr: begin
        dec.operand2_sel = 1'b1;
        dec.we_regfile   = 1'b1;
        dec.j_pc         = 1'b1;
        dec.rd_sel       = 2'b10;
        imm_sel          = imm_i;
      end
      OpcLui: begin
        dec.operand1_sel = 2'b10;
        dec.operand2_sel = 1'b1;
        dec.we_regfile   = 1'b1;
        imm_sel          = imm_u;
      end
      OpcAuipc: begin
        dec.operand1_sel = 2'b01;
        dec.operand2_sel = 1'b1;
        dec.we_regfile   = 1'b1;
        imm_sel          = imm_u;
      end
      OpcFence: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
    dec.imm = XLEN'(imm_sel);
    // An undecodable word still flows downstream, but can never change architectural state.
    if (!legal) begin
      dec.we_regfile = 1'b0;
      dec.we_datamem = 1'b0;
      dec.re_datamem = 1'b0;
      dec.we_pc      = 1'b0;
      dec.j_pc       = 1'b0;
      dec.illegal    = 1'b1;
    end
  end

  logic accept;
  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = dec;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && out_ready) begin
          main_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = StTwo;
        end else if (out_ready) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != StEmpty);
  assign out_pc       = main_q.pc;
  assign rs1          = main_q.rs1;
  assign rs2          = main_q.rs2;
  assign rd           = main_q.rd;
  assign imm          = main_q.imm;
  assign we_regfile   = main_q.we_regfile;
  assign we_datamem   = main_q.we_datamem;
  assign re_datamem   = main_q.re_datamem;
  assign we_pc        = main_q.we_pc;
  assign j_pc         = main_q.j_pc;
  assign ALU_sel_1    = main_q.alu_sel_1;
  assign ALU_sel_2    = main_q.alu_sel_2;
  assign alu_m        = main_q.alu_m;
  assign operand1_sel = main_q.operand1_sel;
  assign operand2_sel = main_q.operand2_sel;
  assign rd_sel       = main_q.rd_sel;
  assign illegal      = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV32 (ENABLE_M=0) and an RV64 (ENABLE_M=1) instance share stimulus
// and are compared each cycle against a queue-based handshake model and an arithmetic decoder.
module tb_decode_stage;

  typedef logic [158:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_pc0, imm0;
  logic [63:0] out_pc1, imm1;
  logic [4:0]  rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
  logic        wr0, wd0, rdm0, wp0, jp0, s2_0, am0, o2_0, ill0;
  logic        wr1, wd1, rdm1, wp1, jp1, s2_1, am1, o2_1, ill1;
  logic [2:0]  s1_0, s1_1;
  logic [1:0]  o1_0, o1_1, rsel0, rsel1;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(out_pc0), .rs1(rs1_0), .rs2(rs2_0), .rd(rd_0), .imm(imm0), .we_regfile(wr0),
    .we_datamem(wd0), .re_datamem(rdm0), .we_pc(wp0), .j_pc(jp0), .ALU_sel_1(s1_0),
    .ALU_sel_2(s2_0), .alu_m(am0), .operand1_sel(o1_0), .operand2_sel(o2_0), .rd_sel(rsel0),
    .illegal(ill0)
  );

  decode_stage #(.XLEN(64), .ENABLE_M(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_pc(out_pc1), .rs1(rs1_1), .rs2(rs2_1), .rd(rd_1), .imm(imm1), .we_regfile(wr1),
    .we_datamem(wd1), .re_datamem(rdm1), .we_pc(wp1), .j_pc(jp1), .ALU_sel_1(s1_1),
    .ALU_sel_2(s2_1), .alu_m(am1), .operand1_sel(o1_1), .operand2_sel(o2_1), .rd_sel(rsel1),
    .illegal(ill1)
  );

  always #5 clk = ~clk;

  vec_t obs0, obs1;
  assign obs0 = {32'b0, out_pc0, rs1_0, rs2_0, rd_0, {{32{imm0[31]}}, imm0}, wr0, wd0, rdm0, wp0,
                 jp0, s1_0, s2_0, am0, o1_0, o2_0, rsel0, ill0};
  assign obs1 = {out_pc1, rs1_1, rs2_1, rd_1, imm1, wr1, wd1, rdm1, wp1, jp1, s1_1, s2_1, am1,
                 o1_1, o2_1, rsel1, ill1};

  int   n_assert = 0;
  int   n_fail   = 0;
  vec_t q0[$];
  vec_t q1[$];

  task automatic chk(string tag, vec_t o, vec_t e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic longint sx(longint v, int n);
    return (v >= (longint'(1) << (n - 1))) ? v - (longint'(1) << n) : v;
  endfunction

  // Reference decode written straight from the opcode table and immediate bit maps.
  function automatic vec_t ref_decode(logic [31:0] ins, logic [63:0] pc, bit m_en);
    longint     immv = 0;
    logic       ok = 1'b1, wr = 0, wd = 0, rdm = 0, wp = 0, jp = 0, s2 = 0, am = 0, o2 = 0;
    logic [2:0] s1 = 0, f3;
    logic [6:0] f7;
    logic [1:0] o1 = 0, rsel = 0;
    longint     vi, vs, vb, vu, vj;
    f3 = ins[14:12];
    f7 = ins[31:25];
    vi = sx(longint'(ins[31:20]), 12);
    vs = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
    vb = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
            + longint'(ins[11:8]) * 2, 13);
    vu = sx(longint'(ins[31:12]) * 4096, 32);
    vj = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
            + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
    case (ins[6:0])
      7'h33: begin
        wr = 1; s1 = f3;
        am = m_en && f7 == 7'h01;
        s2 = am ? 1'b0 : ins[30];
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || am;
      end
      7'h13: begin o2 = 1; wr = 1; s1 = f3; s2 = (f3 == 5) ? ins[30] : 1'b0; immv = vi; end
      7'h03: begin o2 = 1; wr = 1; rdm = 1; rsel = 2'b01; immv = vi; end
      7'h23: begin o2 = 1; wd = 1; immv = vs; end
      7'h63: begin o1 = 2'b01; o2 = 1; wp = 1; immv = vb; end
      7'h6f: begin o1 = 2'b01; o2 = 1; wr = 1; jp = 1; rsel = 2'b10; immv = vj; end
      7'h67: begin o2 = 1; wr = 1; jp = 1; rsel = 2'b10; immv = vi; end
      7'h37: begin o1 = 2'b10; o2 = 1; wr = 1; immv = vu; end
      7'h17: begin o1 = 2'b01; o2 = 1; wr = 1; immv = vu; end
      7'h0f: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!ok) begin wr = 0; wd = 0; rdm = 0; wp = 0; jp = 0; end
    return {pc, ins[19:15], ins[24:20], ins[11:7], 64'(immv), wr, wd, rdm, wp, jp, s1, s2, am,
            o1, o2, rsel, ~ok};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6f;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;  default: w[6:0] = 7'h0f;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_outputs();
    chk("in_ready0", vec_t'(in_ready0), vec_t'(q0.size() < 2));
    chk("in_ready1", vec_t'(in_ready1), vec_t'(q1.size() < 2));
    chk("out_valid0", vec_t'(out_valid0), vec_t'(q0.size() > 0));
    chk("out_valid1", vec_t'(out_valid1), vec_t'(q1.size() > 0));
    if (q0.size() > 0) chk("bundle0", obs0, q0[0]);
    if (q1.size() > 0) chk("bundle1", obs1, q1[0]);
  endtask

  // One clock: drive, let the edge happen, advance the model, sample 1 time unit later.
  task automatic step(bit v, logic [31:0] ins, logic [63:0] p, bit ordy, bit fl, bit rn);
    bit acc;
    in_valid = v; in_instr = ins; in_pc = p; out_ready = ordy; flush = fl; rst_n = rn;
    acc = v && (q0.size() < 2);
    @(posedge clk);
    if (!rn || fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (ordy && q0.size() > 0) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (acc) begin
        q0.push_back(ref_decode(ins, {32'b0, p[31:0]}, 1'b0));
        q1.push_back(ref_decode(ins, p, 1'b1));
      end
    end
    #1;
    check_outputs();
  endtask

  localparam logic [31:0] I1 = 32'h00100093;
  localparam logic [31:0] I2 = 32'h00200113;
  localparam logic [31:0] I3 = 32'h00300193;

  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_bundle0", obs0, '0);
    chk("rst_bundle1", obs1, '0);

    step(1, 32'h002081B3, 64'h100, 1, 0, 1);
    chk("add_rs1", vec_t'(rs1_0), vec_t'(5'd1));
    chk("add_rs2", vec_t'(rs2_0), vec_t'(5'd2));
    chk("add_rd", vec_t'(rd_0), vec_t'(5'd3));
    chk("add_sel", vec_t'({s1_0, s2_0, wr0, ill0}), vec_t'(6'b000_0_1_0));

    step(1, 32'hFFF00093, 64'h104, 1, 0, 1);
    chk("addi_imm32", vec_t'(imm0), vec_t'(32'hFFFF_FFFF));
    chk("addi_imm64", vec_t'(imm1), vec_t'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("addi_sel2", vec_t'(s2_0), vec_t'(1'b0));

    step(1, 32'h4032D293, 64'h108, 1, 0, 1);
    chk("srai_sel2", vec_t'(s2_0), vec_t'(1'b1));
    chk("srai_shamt", vec_t'(imm0[4:0]), vec_t'(5'd3));

    step(1, 32'hFE000CE3, 64'h10C, 1, 0, 1);
    chk("beq_imm", vec_t'(imm0), vec_t'(32'hFFFF_FFF8));
    chk("beq_ctl", vec_t'({o1_0, wp0}), vec_t'(3'b01_1));

    step(1, 32'h00001097, 64'h110, 1, 0, 1);
    chk("auipc_imm", vec_t'(imm0), vec_t'(32'h0000_1000));
    chk("auipc_ctl", vec_t'({o1_0, wr0, jp0}), vec_t'(4'b01_1_0));

    step(1, 32'h00000000, 64'h114, 1, 0, 1);
    chk("zero_ill", vec_t'({ill0, wr0, wd0, rdm0, wp0, jp0}), vec_t'(6'b100000));

    step(1, 32'h023100B3, 64'h118, 1, 0, 1);
    chk("mul_m0", vec_t'({ill0, wr0, am0}), vec_t'(3'b100));
    chk("mul_m1", vec_t'({ill1, wr1, am1}), vec_t'(3'b011));
    step(0, 0, 0, 1, 0, 1);

    // Backpressure: third instruction must wait while both entries are full.
    step(1, I1, 64'h200, 0, 0, 1);
    step(1, I2, 64'h204, 0, 0, 1);
    chk("bp_ready_low", vec_t'(in_ready0), vec_t'(1'b0));
    step(1, I3, 64'h208, 0, 0, 1);
    chk("bp_hold_rd1", vec_t'(rd_0), vec_t'(5'd1));
    step(1, I3, 64'h208, 1, 0, 1);
    chk("bp_rd2", vec_t'(rd_0), vec_t'(5'd2));
    step(1, I3, 64'h208, 1, 0, 1);
    chk("bp_rd3", vec_t'(rd_0), vec_t'(5'd3));
    step(0, 0, 0, 1, 0, 1);
    chk("bp_drained", vec_t'(out_valid0), vec_t'(1'b0));

    // Flush while full, with a simultaneous offer that must be dropped.
    step(1, I1, 64'h300, 0, 0, 1);
    step(1, I2, 64'h304, 0, 0, 1);
    step(1, I3, 64'h308, 1, 1, 1);
    chk("flush_state", vec_t'({out_valid0, in_ready0}), vec_t'(2'b01));
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);

    step(1, I1, 64'h400, 0, 0, 1);
    step(1, I2, 64'h404, 0, 0, 1);
    step(1, I3, 64'h408, 1, 1, 0);
    chk("rst_mid_bundle0", obs0, '0);
    chk("rst_mid_state", vec_t'({out_valid0, in_ready0}), vec_t'(2'b01));

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, $urandom_range(0, 99) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
